memory_stage_lsu: RTL and testbench

//  Load/store unit of the MEM stage; sits directly upstream of the MEM/WB pipeline register.

---
 rtl/memory_stage_lsu.sv | 172 +++++++++++++++++
 tb/tb_memory_stage_lsu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_lsu.sv
// MEM-stage load/store unit: turns an EX/MEM load/store into a req/ack data-memory
// transaction, aligns/extends load data for MEM/WB and stalls the pipe while busy.
module memory_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_vld,
  input  logic        i_mem_rden,
  input  logic        i_mem_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_bmask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_ld_vld,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misaligned_q, misaligned_d;
  logic        timeout_q, timeout_d;

  logic        start;
  logic        misalign;
  logic [1:0]  size;
  logic [3:0]  req_bmask;
  logic [31:0] req_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // funct3[1:0]: 00 byte, 01 half, anything else behaves as a word
  assign size     = i_funct3[1:0];
  assign start    = (state_q == ST_IDLE) && i_vld && (i_mem_rden || i_mem_wren);
  assign misalign = ((size == 2'b01) && i_addr[0]) || (size[1] && (i_addr[1:0] != 2'b00));

  always_comb begin
    req_bmask = 4'b1111;
    req_wdata = i_st_data;
    case (size)
      2'b00: begin
        req_bmask = 4'b0001 << i_addr[1:0];
        req_wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        req_bmask = i_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_byte = i_dmem_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    bmask_d      = bmask_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    ld_data_d    = ld_data_q;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (misalign) begin
            misaligned_d = 1'b1;
          end else begin
            state_d  = ST_REQ;
            cnt_d    = 8'd0;
            addr_d   = {i_addr[31:2], 2'b00};
            we_d     = i_mem_wren;
            bmask_d  = req_bmask;
            wdata_d  = req_wdata;
            funct3_d = i_funct3;
            off_d    = i_addr[1:0];
          end
        end
      end
      ST_REQ: begin
        if (i_dmem_ack) begin
          state_d = ST_RESP;
          if (!we_q) ld_data_d = rd_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 32'd0;
      we_q         <= 1'b0;
      bmask_q      <= 4'd0;
      wdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      ld_data_q    <= 32'd0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      bmask_q      <= bmask_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      ld_data_q    <= ld_data_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_dmem_req   = (state_q == ST_REQ);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_bmask = bmask_q;
  assign o_dmem_wdata = wdata_q;
  assign o_ld_data    = ld_data_q;
  assign o_ld_vld     = (state_q == ST_RESP) && !we_q;
  // Released in RESP so the MEM/WB register captures the load result
  assign o_stall      = (start && !misalign) || (state_q == ST_REQ);
  assign o_misaligned = misaligned_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Bench for memory_stage_lsu: directed scenarios plus randomized loads/stores checked
// against an arithmetic reference model of lane masks, replication and extension.
module tb_memory_stage_lsu;

  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_vld;
  logic        i_mem_rden;
  logic        i_mem_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_bmask;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_ld_data;
  logic        o_ld_vld;
  logic        o_stall;
  logic        o_misaligned;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_ld = 32'd0;

  always #5 i_clk = ~i_clk;

  memory_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_vld(i_vld), .i_mem_rden(i_mem_rden),
    .i_mem_wren(i_mem_wren), .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_bmask(o_dmem_bmask), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_ld_data(o_ld_data), .o_ld_vld(o_ld_vld),
    .o_stall(o_stall), .o_misaligned(o_misaligned), .o_timeout(o_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_bmask(input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    case (int'(f3 % 4))
      0:       return 4'(1 << off);
      1:       return 4'(3 << ((off / 2) * 2));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] st);
    case (int'(f3 % 4))
      0:       return (st % 256) * 32'h0101_0101;
      1:       return (st % 65536) * 32'h0001_0001;
      default: return st;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    int off = int'(a % 4);
    b = (rd >> (8 * off)) % 256;
    h = (rd >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit m_misalign(input logic [2:0] f3, input logic [31:0] a);
    int sz = int'(f3 % 4);
    if (sz == 1) return (a % 2) != 0;
    if (sz >= 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] st, input int ack_dly, input logic [31:0] rd);
    bit mis = m_misalign(f3, a);
    bit acked = 1'b0;
    i_vld = 1'b1; i_mem_rden = ld; i_mem_wren = !ld;
    i_funct3 = f3; i_addr = a; i_st_data = st;
    #1;
    chk("start_stall", 32'(o_stall), mis ? 32'd0 : 32'd1);
    chk("start_req", 32'(o_dmem_req), 32'd0);
    next_cycle();
    i_vld = 1'b0; i_mem_rden = 1'b0; i_mem_wren = 1'b0;
    i_addr = $urandom; i_st_data = $urandom;
    #1;
    if (mis) begin
      chk("misaligned_pulse", 32'(o_misaligned), 32'd1);
      chk("misaligned_req", 32'(o_dmem_req), 32'd0);
      chk("misaligned_stall", 32'(o_stall), 32'd0);
      next_cycle(); #1;
      chk("misaligned_clear", 32'(o_misaligned), 32'd0);
      chk("misaligned_req2", 32'(o_dmem_req), 32'd0);
      $display("txn %s f3=%0d addr=0x%08h misaligned", ld ? "LD" : "ST", f3, a);
      return;
    end
    for (int k = 0; k < T && !acked; k++) begin
      chk("req_high", 32'(o_dmem_req), 32'd1);
      chk("req_we", 32'(o_dmem_we), ld ? 32'd0 : 32'd1);
      chk("req_addr", o_dmem_addr, a & 32'hFFFF_FFFC);
      chk("req_bmask", 32'(o_dmem_bmask), 32'(m_bmask(f3, a)));
      if (!ld) chk("req_wdata", o_dmem_wdata, m_wdata(f3, st));
      chk("req_stall", 32'(o_stall), 32'd1);
      chk("req_ld_vld", 32'(o_ld_vld), 32'd0);
      if (k == ack_dly) begin
        i_dmem_ack = 1'b1; i_dmem_rdata = rd; acked = 1'b1;
      end
      next_cycle();
      i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
      #1;
    end
    if (acked) begin
      if (ld) model_ld = m_load(f3, a, rd);
      chk("resp_req", 32'(o_dmem_req), 32'd0);
      chk("resp_stall", 32'(o_stall), 32'd0);
      chk("resp_ld_vld", 32'(o_ld_vld), ld ? 32'd1 : 32'd0);
      chk("resp_ld_data", o_ld_data, model_ld);
      chk("resp_timeout", 32'(o_timeout), 32'd0);
      next_cycle(); #1;
      chk("post_ld_vld", 32'(o_ld_vld), 32'd0);
      chk("post_stall", 32'(o_stall), 32'd0);
      chk("post_req", 32'(o_dmem_req), 32'd0);
      $display("txn %s f3=%0d addr=0x%08h st=0x%08h rd=0x%08h ack@%0d ld_data=0x%08h",
               ld ? "LD" : "ST", f3, a, st, rd, ack_dly, o_ld_data);
    end else begin
      chk("timeout_pulse", 32'(o_timeout), 32'd1);
      chk("timeout_req", 32'(o_dmem_req), 32'd0);
      chk("timeout_stall", 32'(o_stall), 32'd0);
      chk("timeout_ld_vld", 32'(o_ld_vld), 32'd0);
      next_cycle(); #1;
      chk("timeout_clear", 32'(o_timeout), 32'd0);
      chk("timeout_ld_data", o_ld_data, model_ld);
      $display("txn %s f3=%0d addr=0x%08h timed out", ld ? "LD" : "ST", f3, a);
    end
  endtask

  initial begin
    logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    i_reset = 1'b1; i_vld = 1'b0; i_mem_rden = 1'b0; i_mem_wren = 1'b0;
    i_funct3 = 3'd0; i_addr = 32'd0; i_st_data = 32'd0;
    i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
    repeat (2) next_cycle();
    i_reset = 1'b0;
    #1;
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_we", 32'(o_dmem_we), 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_bmask", 32'(o_dmem_bmask), 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_ld_data", o_ld_data, 32'd0);
    chk("rst_ld_vld", 32'(o_ld_vld), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    $display("reset state checked");

    run_txn(1'b1, 3'd2, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF);
    chk("lw_deadbeef", o_ld_data, 32'hDEAD_BEEF);
    run_txn(1'b1, 3'd0, 32'h0000_0103, 32'd0, 1, 32'h80FF_0000);
    chk("lb_sign", o_ld_data, 32'hFFFF_FF80);
    run_txn(1'b1, 3'd4, 32'h0000_0103, 32'd0, 2, 32'h80FF_0000);
    chk("lbu_zero", o_ld_data, 32'h0000_0080);
    run_txn(1'b0, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0);
    chk("sh_keeps_ld", o_ld_data, 32'h0000_0080);
    run_txn(1'b1, 3'd2, 32'h0000_0102, 32'd0, 0, 32'h0);
    run_txn(1'b1, 3'd2, 32'h0000_0300, 32'd0, T + 3, 32'h0);

    // Ack arriving while idle must not produce a load result
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
    next_cycle();
    i_dmem_ack = 1'b0;
    #1;
    chk("stray_ack_vld", 32'(o_ld_vld), 32'd0);
    chk("stray_ack_data", o_ld_data, model_ld);
    $display("stray ack ignored");

    // Reset during the second REQ cycle, then a late ack
    i_vld = 1'b1; i_mem_rden = 1'b1; i_funct3 = 3'd2; i_addr = 32'h0000_0040;
    next_cycle();
    i_vld = 1'b0; i_mem_rden = 1'b0;
    #1;
    chk("rstreq_req1", 32'(o_dmem_req), 32'd1);
    next_cycle(); #1;
    chk("rstreq_req2", 32'(o_dmem_req), 32'd1);
    i_reset = 1'b1;
    next_cycle();
    i_reset = 1'b0; i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1234_5678;
    model_ld = 32'd0;
    #1;
    chk("rstreq_req_low", 32'(o_dmem_req), 32'd0);
    chk("rstreq_addr", o_dmem_addr, 32'd0);
    chk("rstreq_stall", 32'(o_stall), 32'd0);
    next_cycle();
    i_dmem_ack = 1'b0;
    #1;
    chk("rstreq_ld_vld", 32'(o_ld_vld), 32'd0);
    chk("rstreq_ld_data", o_ld_data, 32'd0);
    chk("rstreq_req_after", 32'(o_dmem_req), 32'd0);
    $display("reset mid-request checked");

    for (int n = 0; n < 60; n++) begin
      bit ld = 1'($urandom % 2);
      logic [2:0] f3 = ld ? ld_codes[$urandom % 5] : 3'($urandom % 3);
      logic [31:0] a = $urandom;
      int dly = ($urandom % 8 == 0) ? T + 1 : int'($urandom % 3);
      if ($urandom % 3 != 0) a = a & ~((f3 % 4 == 1) ? 32'd1 : (f3 % 4 == 0) ? 32'd0 : 32'd3);
      run_txn(ld, f3, a, $urandom, dly, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
